alu_issue: RTL and testbench
============================

# alu_issue

Operand-issue and write-back sequencer that sits directly upstream and downstream of the combinational ALU. It accepts one decoded instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's `op`/`a`/`b` inputs, captures `result`/`zero`, and writes the result back to the destination register. Fixed 3-state FSM; one instruction per 3 cycles.

## Interface
- `NREG`, 8: number of 32-bit registers; must be a power of two. `r0` is hardwired to zero.
- `AW`, log2(NREG) = 3: register address width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: block can accept; high only in IDLE.
- `in_op` input 4: ALU opcode. AND=0000, OR=0001, ADD=0010, SUB=0011, XOR=0101.
- `in_rd`, `in_rs1`, `in_rs2` input AW each: destination and source register indices.
- `in_imm_en` input 1: when 1, operand b is the sign-extended `in_imm` instead of `rf[rs2]`.
- `in_imm` input 16: immediate.
- `alu_op` output 4; `alu_a`, `alu_b` output 32: drive the ALU.
- `alu_result` input 32; `alu_zero` input 1: ALU outputs, combinational from `alu_op`/`alu_a`/`alu_b`.
- `done` output 1: one-cycle completion pulse.
- `done_result` output 32; `done_zero` output 1: captured ALU outputs, valid while `done` is high.
- `illegal` output 1: valid with `done`; high if the opcode is not one of the five legal codes.
- `dbg_addr` input AW; `dbg_data` output 32: combinational register read; `r0` reads 0.

## Operation
- States: IDLE, EXEC, WB.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch op, rd, rs1, rs2, imm_en and sign-extended imm; go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC**
  - `alu_op` = latched op.
  - `alu_a` = `rf[rs1]`.
  - `alu_b` = imm_en ? sext(imm) : `rf[rs2]`.
  - At the cycle end, capture `alu_result` and `alu_zero` into `done_result` and `done_zero`.
  - Set the illegal flag from the opcode decode; go to WB.
- **WB**
  - `done`=1 and `illegal` reflects the decode.
  - At the cycle end, write `rf[rd]` = captured result, unless rd==0 or the opcode is illegal.
  - Go to IDLE.
- Illegal opcode:
  - The ALU is still driven; its output is ignored.
  - `done_result` is forced to 0 and `done_zero` to 1.
  - No register write.
- Outside EXEC, `alu_op`, `alu_a` and `alu_b` are driven to 0.
- A write to r0 is discarded; `rf[0]` always reads 0.
- Arithmetic is the ALU's 32-bit wrap-around; this block adds no width extension or overflow detection.
- Reset, including mid-operation:
  - State returns to IDLE and all registers become 0.
  - All outputs take their reset values. The in-flight instruction is dropped with no `done` and no write.
- Reset values:
  - `in_ready`=0 during reset and 1 in the first cycle after reset.
  - `done`=0, `done_result`=0, `done_zero`=0, `illegal`=0.
  - `alu_op`=0, `alu_a`=0, `alu_b`=0.

## Timing
- Accept at edge E0 (`in_valid` & `in_ready`).
- EXEC occupies the cycle E0–E1; capture at E1.
- WB occupies the cycle E1–E2, with `done` high throughout; the register write commits at E2.
- Back in IDLE after E2; the next accept is possible at E3.
- Throughput: 1 instruction per 3 cycles.
- Read-after-write needs no forwarding: the write commits at E2, before the next EXEC reads.
- `in_valid` held high while `in_ready`=0 has no effect. The upstream keeps its instruction stable until accepted.
- `dbg_data` is combinational from `rf`. A WB write is visible on `dbg_data` the cycle after E2.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR.
  - Function `op_legal(op)`.
  - FSM state enum IDLE/EXEC/WB.
  - The ALU itself uses the same opcode constants.
- One sub-module: `reg_file`.
  - NREG×32 storage, two combinational read ports plus a debug read port, one synchronous write port.
  - r0 forced to zero; synchronous reset clears all entries.
- The FSM, instruction latch, immediate sign-extension and capture registers live in `alu_issue`.
- The testbench instantiates `alu_issue` together with the ALU.

## Test plan
- After reset, set `r1` = 5, `r2` = 3 via ADD-imm from `r0`. Then issue ADD `r3`,`r1`,`r2`. Required: `done` in the WB cycle with `done_result`=8, `done_zero`=0, and `dbg_data` of `r3` reads 8.
- SUB `r4`,`r1`,`r1`: `done_result`=0 and `done_zero`=1. Then ADD-imm `r5`,`r0`,imm=0xFFFF: `r5`=0xFFFFFFFF, checking sign extension.
- Back-to-back: ADD `r6`,`r1`,`r2`, then XOR `r7`,`r6`,`r1` offered with `in_valid` held high. Required: `r7`=8^5=13 and accepts spaced exactly 3 cycles apart.
- Illegal opcode 0100 with rd=`r3`: `done`=1, `illegal`=1, `done_result`=0, and `r3` is unchanged at 8. Also ADD to `r0`: `dbg_data` of `r0` stays 0.
- Wrap-around: `r1` = 0x7FFFFFFF (built via immediates and OR), ADD `r2`,`r1`,`r1`. Required: 0xFFFFFFFE, `zero`=0.
- Assert `rst` during EXEC: no `done` pulse, all registers read 0, and `in_ready`=1 the cycle after reset is released.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue/write-back sequencer:
// opcode encodings, legality decode and the sequencer state type.
package alu_pkg;

    localparam int DW = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU driven by alu_issue; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/reg_file.sv
// NREG x 32 register file: two operand read ports, a debug read port and
// one synchronous write port. Entry 0 is never written and always reads 0.
module reg_file
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (i != 0) && (waddr == AW'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata1   = (raddr1   == '0) ? '0 : regs_q[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : regs_q[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue / write-back sequencer around a combinational ALU:
// IDLE accepts an instruction, EXEC drives the ALU and captures, WB writes back.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          in_imm_en,
    input  logic [15:0]   in_imm,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    output logic          done,
    output logic [DW-1:0] done_result,
    output logic          done_zero,
    output logic          illegal,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rs1_q, rs1_d;
    logic [AW-1:0] rs2_q, rs2_d;
    logic          imm_en_q, imm_en_d;
    logic [DW-1:0] imm_q, imm_d;
    logic          done_q, done_d;
    logic [DW-1:0] done_result_q, done_result_d;
    logic          done_zero_q, done_zero_d;
    logic          illegal_q, illegal_d;

    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          rf_we;
    logic          exec_legal;

    // Write-back happens in the last WB cycle; reset takes priority inside reg_file.
    assign rf_we = (state_q == WB) && !illegal_q && (rd_q != '0);

    reg_file #(
        .NREG (NREG),
        .AW   (AW)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (done_result_q),
        .raddr1   (rs1_q),
        .rdata1   (rs1_data),
        .raddr2   (rs2_q),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign exec_legal = op_legal(op_q);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        imm_en_d      = imm_en_q;
        imm_d         = imm_q;
        done_d        = 1'b0;
        done_result_d = done_result_q;
        done_zero_d   = done_zero_q;
        illegal_d     = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d     = in_op;
                    rd_d     = in_rd;
                    rs1_d    = in_rs1;
                    rs2_d    = in_rs2;
                    imm_en_d = in_imm_en;
                    imm_d    = {{16{in_imm[15]}}, in_imm};
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                done_d        = 1'b1;
                illegal_d     = !exec_legal;
                done_result_d = exec_legal ? alu_result : '0;
                done_zero_d   = exec_legal ? alu_zero : 1'b1;
                state_d       = WB;
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_en_q      <= 1'b0;
            imm_q         <= '0;
            done_q        <= 1'b0;
            done_result_q <= '0;
            done_zero_q   <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            imm_en_q      <= imm_en_d;
            imm_q         <= imm_d;
            done_q        <= done_d;
            done_result_q <= done_result_d;
            done_zero_q   <= done_zero_d;
            illegal_q     <= illegal_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign alu_op      = (state_q == EXEC) ? op_q : 4'b0000;
    assign alu_a       = (state_q == EXEC) ? rs1_data : '0;
    assign alu_b       = (state_q == EXEC) ? (imm_en_q ? imm_q : rs2_data) : '0;
    assign done        = done_q;
    assign done_result = done_result_q;
    assign done_zero   = done_zero_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with the ALU attached: directed test-plan
// steps, then random instructions checked against an architectural register model.
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [2:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic        in_imm_en = 1'b0;
    logic [15:0] in_imm = '0;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic        done, done_zero, illegal;
    logic [31:0] done_result;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    logic [31:0] model_rf [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue #(.NREG(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .done(done), .done_result(done_result), .done_zero(done_zero),
        .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    alu u_alu (
        .op(alu_op), .a(alu_a), .b(alu_b), .result(alu_result), .zero(alu_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each opcode, straight from the opcode table.
    task automatic ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output bit legal);
        legal = 1'b1;
        res   = 32'd0;
        case (op)
            4'd0:    res = a & b;
            4'd1:    res = a | b;
            4'd2:    res = a + b;
            4'd3:    res = a - b;
            4'd5:    res = a ^ b;
            default: legal = 1'b0;
        endcase
    endtask

    task automatic dbg_read(input int r, output logic [31:0] val);
        dbg_addr = 3'(r);
        #1;
        val = dbg_data;
    endtask

    task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                         input bit imm_en, input logic [15:0] imm, input bit hold_valid);
        logic [31:0] a_exp, b_exp, r_exp, rd_val;
        bit legal;
        int waited;
        in_op = op; in_rd = 3'(rd); in_rs1 = 3'(rs1); in_rs2 = 3'(rs2);
        in_imm_en = imm_en; in_imm = imm; in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 10) begin
            @(posedge clk); #1; waited++;
        end
        if (in_ready !== 1'b1) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        a_exp = model_rf[rs1];
        b_exp = imm_en ? 32'($signed(imm)) : model_rf[rs2];
        ref_exec(op, a_exp, b_exp, r_exp, legal);
        @(posedge clk); #1;
        accept_cyc = cyc;
        if (!hold_valid) in_valid = 1'b0;
        check("exec_alu_op", {28'd0, alu_op}, {28'd0, op});
        check("exec_alu_a", alu_a, a_exp);
        check("exec_alu_b", alu_b, b_exp);
        check("exec_no_done", {31'd0, done}, 32'd0);
        check("exec_not_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("wb_done", {31'd0, done}, 32'd1);
        check("wb_result", done_result, legal ? r_exp : 32'd0);
        check("wb_zero", {31'd0, done_zero}, legal ? {31'd0, r_exp == 32'd0} : 32'd1);
        check("wb_illegal", {31'd0, illegal}, {31'd0, !legal});
        check("wb_alu_idle", alu_a | alu_b | {28'd0, alu_op}, 32'd0);
        @(posedge clk); #1;
        if (legal && rd != 0) model_rf[rd] = r_exp;
        check("idle_done_low", {31'd0, done}, 32'd0);
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        dbg_read(rd, rd_val);
        check("wb_dbg_rd", rd_val, model_rf[rd]);
    endtask

    initial begin
        logic [31:0] v;
        int prev_acc;
        logic [3:0] legal_ops [5];
        legal_ops[0] = 4'd0; legal_ops[1] = 4'd1; legal_ops[2] = 4'd2;
        legal_ops[3] = 4'd3; legal_ops[4] = 4'd5;
        for (int i = 0; i < 8; i++) model_rf[i] = 32'd0;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_done_result", done_result, 32'd0);
        check("rst_done_zero", {31'd0, done_zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_alu", alu_a | alu_b | {28'd0, alu_op}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // r1=5, r2=3, r3=r1+r2
        issue(OP_ADD, 1, 0, 0, 1'b1, 16'd5, 1'b0);
        issue(OP_ADD, 2, 0, 0, 1'b1, 16'd3, 1'b0);
        issue(OP_ADD, 3, 1, 2, 1'b0, 16'd0, 1'b0);
        dbg_read(3, v);
        check("r3_is_8", v, 32'd8);
        issue(OP_SUB, 4, 1, 1, 1'b0, 16'd0, 1'b0);
        issue(OP_ADD, 5, 0, 0, 1'b1, 16'hFFFF, 1'b0);
        dbg_read(5, v);
        check("r5_sext", v, 32'hFFFF_FFFF);

        // Back-to-back with in_valid held high
        issue(OP_ADD, 6, 1, 2, 1'b0, 16'd0, 1'b1);
        prev_acc = accept_cyc;
        issue(OP_XOR, 7, 6, 1, 1'b0, 16'd0, 1'b0);
        check("b2b_spacing", 32'(accept_cyc - prev_acc), 32'd3);
        dbg_read(7, v);
        check("r7_is_13", v, 32'd13);

        // Illegal opcode must not disturb r3; writes to r0 are dropped
        issue(4'b0100, 3, 1, 2, 1'b0, 16'd0, 1'b0);
        dbg_read(3, v);
        check("r3_unchanged", v, 32'd8);
        issue(OP_ADD, 0, 1, 2, 1'b0, 16'd0, 1'b0);
        dbg_read(0, v);
        check("r0_zero", v, 32'd0);

        // Wrap-around: r1 = 0x7FFFFFFF, r2 = r1 + r1
        issue(OP_ADD, 2, 0, 0, 1'b1, 16'd1, 1'b0);
        for (int i = 0; i < 31; i++) issue(OP_ADD, 2, 2, 2, 1'b0, 16'd0, 1'b0);
        issue(OP_ADD, 1, 0, 0, 1'b1, 16'hFFFF, 1'b0);
        issue(OP_XOR, 1, 1, 2, 1'b0, 16'd0, 1'b0);
        issue(OP_OR, 1, 1, 0, 1'b0, 16'd0, 1'b0);
        dbg_read(1, v);
        check("r1_7fffffff", v, 32'h7FFF_FFFF);
        issue(OP_ADD, 2, 1, 1, 1'b0, 16'd0, 1'b0);
        dbg_read(2, v);
        check("wrap_sum", v, 32'hFFFF_FFFE);

        // Random instructions against the register model
        for (int n = 0; n < 30; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                              : legal_ops[$urandom_range(0, 4)];
            issue(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        end

        // Reset during EXEC: instruction dropped, file cleared
        in_op = OP_ADD; in_rd = 3'd3; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_imm_en = 1'b1; in_imm = 16'd77; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_exec_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_alu", alu_a | alu_b | {28'd0, alu_op}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model_rf[i] = 32'd0;
        @(posedge clk); #1;
        check("after_rst_ready", {31'd0, in_ready}, 32'd1);
        check("after_rst_done", {31'd0, done}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_read(r, v);
            check("after_rst_rf", v, 32'd0);
        end
        issue(OP_ADD, 4, 0, 0, 1'b1, 16'h8001, 1'b0);
        dbg_read(4, v);
        check("post_rst_write", v, 32'hFFFF_8001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
